// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and widths for the clock-gate controller slice.
// The state encoding is visible on the debug STATE port, so the enum values are fixed.
package clk_gate_pkg;

    localparam int CG_CNT_W  = 8;
    localparam int CG_STAT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } cg_state_e;

    // Terminal count for a phase that lasts n cycles, counting from zero.
    function automatic logic [CG_CNT_W-1:0] cg_last(input int n);
        return CG_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Control/status bundle between the consuming logic and clock_gate_ctrl.
// The sleep_cnt signal exists only when CLK_GATE_STATS_EN is defined.
interface clock_gate_ctrl_if;
    import clk_gate_pkg::*;

    logic       sleep_en;
    logic       activity;
    logic       wake_req;
    logic       cond;
    logic       cond_en;
    logic       ready;
    logic [1:0] state;
`ifdef CLK_GATE_STATS_EN
    logic [CG_STAT_W-1:0] sleep_cnt;

    modport slave  (input  sleep_en, activity, wake_req,
                    output cond, cond_en, ready, state, sleep_cnt);
    modport master (output sleep_en, activity, wake_req,
                    input  cond, cond_en, ready, state, sleep_cnt);
`else
    modport slave  (input  sleep_en, activity, wake_req,
                    output cond, cond_en, ready, state);
    modport master (output sleep_en, activity, wake_req,
                    input  cond, cond_en, ready, state);
`endif

endinterface

// File: rtl/cg_sat_counter.sv
// Up-counter with synchronous clear (priority) and increment that stops at MAX.
// Shared by the idle, drain, wake and sleep-statistics counters.
module cg_sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Idle-detect controller driving COND/COND_EN of a gated-clock primitive; runs on the free clock.
// Define CLK_GATE_STATS_EN to add the saturating sleep-entry counter on bus.sleep_cnt.
module clock_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_THRESH = 16,
    parameter int DRAIN_CYC   = 4,
    parameter int WAKE_LAT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    clock_gate_ctrl_if.slave   bus
);

    localparam logic [CG_CNT_W-1:0] IDLE_LAST  = cg_last(IDLE_THRESH);
    localparam logic [CG_CNT_W-1:0] DRAIN_LAST = cg_last(DRAIN_CYC);
    localparam logic [CG_CNT_W-1:0] WAKE_LAST  = cg_last(WAKE_LAT);

    cg_state_e           st, st_nxt;
    logic [CG_CNT_W-1:0] idle_cnt, drain_cnt, wake_cnt;
    logic                busy;
    logic                cond_q, cond_en_q, ready_q;
    logic                cond_d, cond_en_d, ready_d;
    logic                idle_clr, idle_inc;
    logic                go_off, go_wake;

    // Any of these keeps the consumer's clock alive.
    assign busy = bus.activity | bus.wake_req | ~bus.sleep_en;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= ST_RUN;
        end else begin
            st <= st_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns st_nxt and no latch is inferred.
        st_nxt = st;
        unique case (st)
            ST_RUN: begin
                if (!busy && (idle_cnt == IDLE_LAST)) st_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (busy)                           st_nxt = ST_RUN;
                else if (drain_cnt == DRAIN_LAST)   st_nxt = ST_OFF;
            end
            ST_OFF: begin
                // The entry cycle still carries the gate-off strobe; a wake strobe
                // right behind it would violate the one-cycle COND_EN spacing.
                if (busy && !cond_en_q)             st_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST)          st_nxt = ST_RUN;
            end
            default:                                st_nxt = ST_RUN;
        endcase
    end

    // ---------------- output / counter-control logic ----------------
    assign go_off  = (st == ST_DRAIN) && (st_nxt == ST_OFF);
    assign go_wake = (st == ST_OFF)   && (st_nxt == ST_WAKE);

    always_comb begin
        cond_d    = cond_q;
        cond_en_d = 1'b0;
        ready_d   = (st_nxt == ST_RUN);
        if (go_off) begin
            cond_d    = 1'b0;
            cond_en_d = 1'b1;
        end else if (go_wake) begin
            cond_d    = 1'b1;
            cond_en_d = 1'b1;
        end
    end

    assign idle_clr = (st != ST_RUN) || busy;
    assign idle_inc = (st == ST_RUN) && !busy;

    // Reset leaves COND_EN low: the primitive resets itself and needs no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q    <= 1'b1;
            cond_en_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            cond_q    <= cond_d;
            cond_en_q <= cond_en_d;
            ready_q   <= ready_d;
        end
    end

    // ---------------- counters ----------------
    cg_sat_counter #(.W(CG_CNT_W), .MAX(IDLE_THRESH)) u_idle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_clr),
        .inc   (idle_inc),
        .count (idle_cnt)
    );

    cg_sat_counter #(.W(CG_CNT_W), .MAX(DRAIN_CYC - 1)) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (st != ST_DRAIN),
        .inc   (st == ST_DRAIN),
        .count (drain_cnt)
    );

    cg_sat_counter #(.W(CG_CNT_W), .MAX(WAKE_LAT - 1)) u_wake_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (st != ST_WAKE),
        .inc   (st == ST_WAKE),
        .count (wake_cnt)
    );

`ifdef CLK_GATE_STATS_EN
    logic [CG_STAT_W-1:0] stat_cnt;

    cg_sat_counter #(.W(CG_STAT_W), .MAX(65535)) u_stat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (go_off),
        .count (stat_cnt)
    );

    assign bus.sleep_cnt = stat_cnt;
`endif

    assign bus.cond    = cond_q;
    assign bus.cond_en = cond_en_q;
    assign bus.ready   = ready_q;
    assign bus.state   = st;

endmodule
